// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
// State encoding, SRAM bus widths and the default SRAM window base.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } state_e;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;
    localparam int CNT_W       = 4;

    localparam logic [31:0] SRAM_BASE_DEF = 32'd1024;

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable 4-bit down-counter timing one SRAM half-access.
// Reloaded at the start of each half; o_done flags the last cycle.
module sram_wait_counter
    import sram_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_value,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    // Load on half start, otherwise count down to zero and park
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/sram_access_ctrl.sv
// MEM-stage controller: splits 32-bit loads/stores into two 16-bit
// SRAM half-accesses and stalls the pipeline. Option: SRAM_POSTED_WRITE_EN.
module sram_access_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int          WAIT_CYCLES = 5,
    parameter logic [31:0] SRAM_BASE   = SRAM_BASE_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_mem_r_en,
    input  logic                   i_mem_w_en,
    input  logic [31:0]            i_addr,
    input  logic [31:0]            i_wdata,
    output logic                   o_ready,
    output logic [31:0]            o_rdata,
    output logic [SRAM_ADDR_W-1:0] o_sram_addr,
    output logic [SRAM_DATA_W-1:0] o_sram_dq_out,
    input  logic [SRAM_DATA_W-1:0] i_sram_dq_in,
    output logic                   o_sram_dq_oe,
    output logic                   o_sram_we_n
);

`ifdef SRAM_POSTED_WRITE_EN
    localparam logic POSTED = 1'b1;
`else
    localparam logic POSTED = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

    state_e      r_state;
    state_e      w_next;
    logic        r_write;
    logic        r_posted;
    logic [16:0] r_word;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;

    logic        w_req;
    logic        w_post;
    logic        w_start;
    logic        w_load;
    logic        w_done;
    logic        w_low;
    logic        w_high;
    logic        w_act;
    logic [31:0] w_off;
    logic [16:0] w_word;

    assign w_req  = i_mem_r_en | i_mem_w_en;
    assign w_post = POSTED & i_mem_w_en;
    assign w_off  = i_addr - SRAM_BASE;
    assign w_word = 17'(w_off >> 2);

    sram_wait_counter u_wait (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_value (LOAD_VAL),
        .o_done  (w_done)
    );

    // State register and request/read-data capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_write  <= 1'b0;
            r_posted <= 1'b0;
            r_word   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_write  <= i_mem_w_en;
                r_posted <= w_post;
                r_word   <= w_word;
                r_wdata  <= i_wdata;
            end
            if (w_low && w_done && !r_write) begin
                r_rdata[15:0] <= i_sram_dq_in;
            end
            if (w_high && w_done && !r_write) begin
                r_rdata[31:16] <= i_sram_dq_in;
            end
        end
    end

    // Next state, pipeline hold and counter reload
    always_comb begin
        w_next  = r_state;
        o_ready = 1'b1;
        w_start = 1'b0;
        w_load  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_start = 1'b1;
                    w_load  = 1'b1;
                    w_next  = LOW;
                    o_ready = w_post;
                end
            end
            LOW: begin
                o_ready = r_posted & ~w_req;
                if (w_done) begin
                    w_load = 1'b1;
                    w_next = HIGH;
                end
            end
            HIGH: begin
                o_ready = r_posted & ~w_req;
                if (w_done) begin
                    w_next = r_posted ? IDLE : DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign w_low  = (r_state == LOW);
    assign w_high = (r_state == HIGH);
    assign w_act  = w_low | w_high;

    assign o_sram_addr   = w_act ? {r_word, w_high} : '0;
    assign o_sram_dq_oe  = w_act & r_write;
    assign o_sram_we_n   = ~o_sram_dq_oe;
    assign o_sram_dq_out = !o_sram_dq_oe ? '0 :
                           w_high ? r_wdata[31:16] : r_wdata[15:0];
    assign o_rdata       = r_rdata;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl with an SRAM model and an
// access scoreboard checked from the SRAM bus monitor.
module tb_sram_access_ctrl;

    localparam int W = 2;

    typedef struct {
        logic [17:0] a;
        logic        w;
        logic [15:0] d;
    } acc_t;

    logic        clk;
    logic        rst;
    logic        i_mem_r_en;
    logic        i_mem_w_en;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_ready;
    logic [31:0] o_rdata;
    logic [17:0] o_sram_addr;
    logic [15:0] o_sram_dq_out;
    logic [15:0] i_sram_dq_in;
    logic        o_sram_dq_oe;
    logic        o_sram_we_n;

    logic [15:0] mem [0:63];
    acc_t        exp_q [$];
    logic [31:0] exp_rdata;
    int          n_chk;
    int          n_pass;

    logic [17:0] m_pa;
    logic        m_pwe;
    logic        m_pact;
    logic        m_act;
    int          m_run;
    acc_t        m_e;

    sram_access_ctrl #(
        .WAIT_CYCLES (W),
        .SRAM_BASE   (32'd1024)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_mem_r_en    (i_mem_r_en),
        .i_mem_w_en    (i_mem_w_en),
        .i_addr        (i_addr),
        .i_wdata       (i_wdata),
        .o_ready       (o_ready),
        .o_rdata       (o_rdata),
        .o_sram_addr   (o_sram_addr),
        .o_sram_dq_out (o_sram_dq_out),
        .i_sram_dq_in  (i_sram_dq_in),
        .o_sram_dq_oe  (o_sram_dq_oe),
        .o_sram_we_n   (o_sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign i_sram_dq_in = mem[o_sram_addr[5:0]];

    always @(posedge clk) begin
        if (!rst && !o_sram_we_n) mem[o_sram_addr[5:0]] <= o_sram_dq_out;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Bus monitor: each new half-access pops one scoreboard entry
    always @(negedge clk) begin
        if (rst) begin
            m_pa   = '0;
            m_pwe  = 1'b1;
            m_run  = 0;
            m_pact = 1'b0;
        end else if (o_sram_addr !== m_pa || o_sram_we_n !== m_pwe) begin
            if (m_pact) chk("half_len", 32'(m_run), 32'(W));
            m_act = (o_sram_addr != '0) || !o_sram_we_n;
            if (m_act) begin
                chk("sb_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    m_e = exp_q.pop_front();
                    chk("half_addr", 32'(o_sram_addr), 32'(m_e.a));
                    chk("half_we_n", 32'(o_sram_we_n), 32'(!m_e.w));
                    chk("half_oe", 32'(o_sram_dq_oe), 32'(m_e.w));
                    if (m_e.w) chk("half_dq", 32'(o_sram_dq_out), 32'(m_e.d));
                end
            end
            m_pa   = o_sram_addr;
            m_pwe  = o_sram_we_n;
            m_run  = 1;
            m_pact = m_act;
        end else begin
            m_run++;
        end
    end

    task automatic push_halves(input logic w, input logic [31:0] a,
                               input logic [31:0] d);
        logic [31:0] off;
        logic [16:0] wd;
        acc_t e;
        off = a - 32'd1024;
        wd  = off[18:2];
        e.a = {wd, 1'b0}; e.w = w; e.d = d[15:0];
        exp_q.push_back(e);
        e.a = {wd, 1'b1}; e.w = w; e.d = d[31:16];
        exp_q.push_back(e);
    endtask

    // Called just after a rising edge; returns just after a rising edge
    task automatic access(input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d,
                          input int exp_stall, input logic [31:0] exp_rd,
                          input string tag);
        int stall;
        push_halves(w, a, d);
        if (!w) exp_rdata = exp_rd;
        i_mem_r_en = r;
        i_mem_w_en = w;
        i_addr     = a;
        i_wdata    = d;
        stall = 0;
        forever begin
            @(negedge clk);
            if (o_ready || stall > 60) break;
            stall++;
        end
        chk({tag, "_stall"}, 32'(stall), 32'(exp_stall));
        chk({tag, "_rdata"}, o_rdata, exp_rdata);
        @(posedge clk);
        #1;
        i_mem_r_en = 1'b0;
        i_mem_w_en = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        exp_rdata = '0;
        for (int i = 0; i < 64; i++) mem[i] = 16'h0;
        mem[4] = 16'h1111;
        mem[5] = 16'h2222;
        rst = 1'b1;
        i_mem_r_en = 1'b0;
        i_mem_w_en = 1'b0;
        i_addr = '0;
        i_wdata = '0;

        @(negedge clk);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_rdata", o_rdata, 32'd0);
        chk("rst_addr", 32'(o_sram_addr), 32'd0);
        chk("rst_dq_out", 32'(o_sram_dq_out), 32'd0);
        chk("rst_oe", 32'(o_sram_dq_oe), 32'd0);
        chk("rst_we_n", 32'(o_sram_we_n), 32'd1);
        i_mem_r_en = 1'b1;
        #1;
        chk("rst_ready_req", 32'(o_ready), 32'd0);
        i_mem_r_en = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        access(1'b1, 1'b0, 32'd1032, 32'h0, 2 * W + 1, 32'h22221111, "rd1032");
        access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 2 * W + 1, 32'h0, "wr1028");
        chk("mem2", 32'(mem[2]), 32'h0000BEEF);
        chk("mem3", 32'(mem[3]), 32'h0000DEAD);

        access(1'b1, 1'b0, 32'd1032, 32'h0, 2 * W + 1, 32'h22221111, "b2b_rd");
        access(1'b0, 1'b1, 32'd1036, 32'h55667788, 2 * W + 1, 32'h0, "b2b_wr");
        chk("b2b_sb_empty", 32'(exp_q.size()), 32'd0);

        access(1'b1, 1'b1, 32'd1024, 32'h12345678, 2 * W + 1, 32'h0, "both");
        chk("both_mem0", 32'(mem[0]), 32'h00005678);
        chk("both_mem1", 32'(mem[1]), 32'h00001234);

`ifdef SRAM_POSTED_WRITE_EN
        access(1'b0, 1'b1, 32'd1028, 32'h01020304, 0, 32'h0, "post_wr");
        access(1'b1, 1'b0, 32'd1032, 32'h0, 4 * W + 1, 32'h22221111, "post_rd");
        chk("post_mem2", 32'(mem[2]), 32'h00000304);
        chk("post_sb_empty", 32'(exp_q.size()), 32'd0);
`endif

        push_halves(1'b1, 32'd1040, 32'hCAFEF00D);
        i_mem_w_en = 1'b1;
        i_addr     = 32'd1040;
        i_wdata    = 32'hCAFEF00D;
        repeat (W + 1) @(posedge clk);
        @(negedge clk);
        chk("mid_we_n", 32'(o_sram_we_n), 32'd0);
        #1;
        rst = 1'b1;
        i_mem_w_en = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_we_n", 32'(o_sram_we_n), 32'd1);
        chk("mid_rst_oe", 32'(o_sram_dq_oe), 32'd0);
        chk("mid_rst_rdata", o_rdata, 32'd0);
        chk("mid_rst_addr", 32'(o_sram_addr), 32'd0);
        chk("mid_rst_ready", 32'(o_ready), 32'd1);
        @(negedge clk);
        #1 rst = 1'b0;
        exp_rdata = '0;
        chk("mid_sb_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;

        access(1'b1, 1'b0, 32'd1032, 32'h0, 2 * W + 1, 32'h22221111, "rd_after");
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("idle_ready", 32'(o_ready), 32'd1);
        chk("end_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sram_access_ctrl.md
# sram_access_ctrl

- Memory-stage controller between the EX/MEM pipeline register and the external 16-bit SRAM.
- Turns each 32-bit load/store into two timed 16-bit SRAM half-accesses.
- Drives `ready`, the pipeline-wide hold. `ready` low freezes every pipeline register, EX/MEM included, until the access completes.

## Interface
Parameters:
- `WAIT_CYCLES`, default 5: cycles per SRAM half-access; legal range 1–15.
- `SRAM_BASE`, default 1024: CPU byte address that maps to SRAM word 0.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `mem_r_en` in 1: load in MEM stage (EX/MEM output).
- `mem_w_en` in 1: store in MEM stage (EX/MEM output).
- `addr` in 32: ALU result, CPU byte address.
- `wdata` in 32: store data (Val_Rm).
- `ready` out 1: 1 = pipeline may advance; 0 = hold all stages.
- `rdata` out 32: load data, valid while `ready`=1 in the DONE cycle.
- `sram_addr` out 18: SRAM half-word address.
- `sram_dq_out` out 16: write data to SRAM.
- `sram_dq_in` in 16: read data from SRAM.
- `sram_dq_oe` out 1: 1 = controller drives the DQ bus.
- `sram_we_n` out 1: SRAM write strobe, active low.

## Operation
- Word index `w = (addr - SRAM_BASE) >> 2`, computed modulo 2^32; bits 1:0 ignored. `sram_addr = {w[16:0], half}`, where half 0 = bits 15:0 and half 1 = bits 31:16.
- If both enables are asserted, the request is treated as a write; reads have no side effects.
- FSM states: IDLE, LOW, HIGH, DONE.
- IDLE:
  - Request present: `ready`=0 combinationally; latch `addr`, `wdata` and direction; go to LOW.
  - No request: `ready`=1.
- LOW:
  - Holds for `WAIT_CYCLES` cycles, counted by the wait counter; `sram_addr` = {w, 0}.
  - Write: `sram_dq_oe`=1, `sram_we_n`=0 for all LOW cycles, `sram_dq_out`=wdata[15:0].
  - Read: `sram_dq_in` captured into rdata[15:0] at the end of the last LOW cycle.
  - Then go to HIGH.
- HIGH: same as LOW, using half 1 and bits 31:16. Then go to DONE.
- DONE: `ready`=1 for exactly one cycle, `rdata` stable, SRAM idle. Next state is IDLE unconditionally.
- The next request is examined in IDLE on the cycle after DONE. By then EX/MEM has advanced, so the stalled instruction is never served twice.
- Outside write half-phases: `sram_we_n`=1, `sram_dq_oe`=0.

## Timing
- Reset values: state IDLE, counter 0, `rdata`=0, `sram_addr`=0, `sram_dq_out`=0, `sram_dq_oe`=0, `sram_we_n`=1. `ready` = 1 if no enable is asserted, else 0.
- Request seen in cycle 0 (state IDLE):
  - LOW occupies cycles 1..W, HIGH occupies cycles W+1..2W, DONE is cycle 2W+1.
  - `ready`=0 for cycles 0..2W, i.e. 2W+1 stall cycles.
- `rdata` is registered; it changes only at half-phase capture edges and holds until the next read.
- Reset mid-access: immediate return to IDLE with reset values. A partial SRAM write is permitted and is not reported.

## Configuration
- Macro: `SRAM_POSTED_WRITE_EN`.
- Defined:
  - One-entry write buffer. A store in IDLE with the buffer empty latches addr/data, keeps `ready`=1 in cycle 0 (no stall), and drains through LOW→HIGH→IDLE. DONE is skipped and `ready` is not held.
  - Any request arriving while the buffer drains holds `ready`=0 until the drain reaches IDLE, then proceeds normally.
- Undefined: stores stall exactly like loads (2W+1 cycles).

## Structure
- Package `sram_ctrl_pkg`:
  - state enum {IDLE, LOW, HIGH, DONE};
  - `SRAM_ADDR_W`=18, `SRAM_DATA_W`=16;
  - default `SRAM_BASE`.
- Sub-module `sram_wait_counter`: 4-bit loadable down-counter with a `done` output, reused by LOW and HIGH.

## Test plan
- W=2, read addr 1032; SRAM[4]=0x1111, SRAM[5]=0x2222 → `sram_addr` is 4 for 2 cycles, then 5 for 2 cycles; `ready` low 5 cycles; DONE `rdata`=0x22221111.
- W=2, write addr 1028, data 0xDEADBEEF → 0xBEEF written at address 2 (`sram_we_n` low 2 cycles), 0xDEAD at address 3; `ready` low 5 cycles (macro off).
- Back-to-back load, store → second access begins the cycle after DONE; no duplicate access to the first address.
- `rst` asserted in HIGH cycle 1 → next cycle state IDLE, `sram_we_n`=1, `sram_dq_oe`=0, `rdata`=0.
- Both enables with addr 1024 → treated as a write to SRAM addresses 0/1; `rdata` unchanged.
- Macro on, W=2: store then load on the next cycle → store costs 0 stall cycles; load waits for the drain, then 5 stall cycles.
